// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU arbiter slice.
package alu_pkg;

    localparam logic [3:0] OP_INVALID   = 4'd0;
    localparam logic [3:0] OP_ADD       = 4'd1;
    localparam logic [3:0] OP_ADD_CARRY = 4'd2;
    localparam logic [3:0] OP_SUB       = 4'd3;
    localparam logic [3:0] OP_INC       = 4'd4;
    localparam logic [3:0] OP_DEC       = 4'd5;
    localparam logic [3:0] OP_AND       = 4'd6;
    localparam logic [3:0] OP_NOT       = 4'd7;
    localparam logic [3:0] OP_ROL       = 4'd8;
    localparam logic [3:0] OP_ROR       = 4'd9;

    localparam int unsigned FLAG_WIDTH   = 5;
    localparam int unsigned FLAG_CARRY   = 0;
    localparam int unsigned FLAG_BORROW  = 1;
    localparam int unsigned FLAG_ZERO    = 2;
    localparam int unsigned FLAG_PARITY  = 3;
    localparam int unsigned FLAG_INVALID = 4;

    typedef logic [FLAG_WIDTH-1:0] flags_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    function automatic flags_t make_flags(input logic invalid_op, input logic parity,
                                          input logic zero, input logic borrow,
                                          input logic carry_out);
        flags_t f;
        f               = '0;
        f[FLAG_INVALID] = invalid_op;
        f[FLAG_PARITY]  = parity;
        f[FLAG_ZERO]    = zero;
        f[FLAG_BORROW]  = borrow;
        f[FLAG_CARRY]   = carry_out;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels between two issuers, the arbiter and the response consumer.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [3:0]           req0_opcode;
    logic [BUS_WIDTH-1:0] req0_a;
    logic [BUS_WIDTH-1:0] req0_b;
    logic                 req0_carry_in;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [3:0]           req1_opcode;
    logic [BUS_WIDTH-1:0] req1_a;
    logic [BUS_WIDTH-1:0] req1_b;
    logic                 req1_carry_in;

    logic                 resp_valid;
    logic                 resp_ready;
    logic                 resp_id;
    logic [BUS_WIDTH-1:0] resp_y;
    flags_t               resp_flags;

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b, req0_carry_in,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_a, req1_b, req1_carry_in,
        input  req1_ready,
        input  resp_valid, resp_id, resp_y, resp_flags,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b, req0_carry_in,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_a, req1_b, req1_carry_in,
        output req1_ready,
        output resp_valid, resp_id, resp_y, resp_flags,
        input  resp_ready
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer remembers the last granted requester.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last_q;

    always_comb begin
        gnt_id = 1'b0;
        if (req == 2'b10) begin
            gnt_id = 1'b1;
        end else if (req == 2'b11) begin
            gnt_id = ~last_q;
        end
        gnt = 2'b00;
        if (en && (req != 2'b00)) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

    // Reset value 1 makes requester 0 win the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_q <= gnt_id;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters; one op in flight at a time.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_arbiter_if.slave         bus,
    output logic [3:0]           alu_opcode,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic                 alu_carry_in,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_carry_out,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] invalid_count
);

    logic [1:0]           state_q, state_d;
    logic                 idle;
    logic [1:0]           arb_req;
    logic [1:0]           arb_gnt;
    logic                 arb_id;
    logic                 accept;
    logic                 id_q;
    logic                 resp_id_q;
    logic [BUS_WIDTH-1:0] resp_y_q;
    flags_t               resp_flags_q;
    logic [CNT_WIDTH-1:0] invalid_count_q;

    assign idle    = (state_q == ST_IDLE);
    assign arb_req = {bus.req1_valid, bus.req0_valid};

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (idle),
        .req    (arb_req),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    assign accept         = (arb_gnt != 2'b00);
    assign bus.req0_ready = arb_gnt[0];
    assign bus.req1_ready = arb_gnt[1];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP:  if (bus.resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            alu_opcode      <= OP_INVALID;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_carry_in    <= 1'b0;
            id_q            <= 1'b0;
            resp_id_q       <= 1'b0;
            resp_y_q        <= '0;
            resp_flags_q    <= '0;
            invalid_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_opcode   <= arb_id ? bus.req1_opcode   : bus.req0_opcode;
                alu_a        <= arb_id ? bus.req1_a        : bus.req0_a;
                alu_b        <= arb_id ? bus.req1_b        : bus.req0_b;
                alu_carry_in <= arb_id ? bus.req1_carry_in : bus.req0_carry_in;
                id_q         <= arb_id;
            end
            // ALU has had the whole ISSUE cycle to settle on the registered inputs.
            if (state_q == ST_ISSUE) begin
                resp_y_q     <= alu_y;
                resp_flags_q <= make_flags(alu_invalid_op, alu_parity, alu_zero,
                                           alu_borrow, alu_carry_out);
                resp_id_q    <= id_q;
                if (alu_invalid_op && (invalid_count_q != {CNT_WIDTH{1'b1}})) begin
                    invalid_count_q <= invalid_count_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_y     = resp_y_q;
    assign bus.resp_flags = resp_flags_q;
    assign busy           = ~idle;
    assign invalid_count  = invalid_count_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU between two independent requesters using valid/ready handshakes and round-robin arbitration.
- Registers the winning request's operands and drives the ALU input pins.
- Captures the ALU result and flags, then returns them on a single tagged response channel.
- Sits between instruction-issue logic and the ALU datapath; the ALU itself is instantiated outside this block.

Parameters:
- BUS_WIDTH, 8, operand/result width; must match the ALU's BUS_WIDTH.
- CNT_WIDTH, 8, width of the saturating invalid-op counter.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_opcode  in  4  ALU opcode
- req0_a, req0_b  in  BUS_WIDTH  operands
- req0_carry_in  in  1  carry input
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b, req1_carry_in  same as req0, for requester 1
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_id  out  1  requester that owns the response
- resp_y  out  BUS_WIDTH  ALU result
- resp_flags  out  5  {invalid_op, parity, zero, borrow, carry_out}
- alu_opcode  out  4  to ALU
- alu_a, alu_b  out  BUS_WIDTH  to ALU
- alu_carry_in  out  1  to ALU
- alu_y  in  BUS_WIDTH  from ALU
- alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op  in  1 each  from ALU
- busy  out  1  high whenever state != IDLE
- invalid_count  out  CNT_WIDTH  saturating count of completed ops with invalid_op=1

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; all outputs 0; alu_opcode=0 (OP_INVALID); invalid_count=0.
  - Round-robin pointer set so that req0 wins the first contention.
  - Reset mid-operation discards any in-flight op; no response is issued for it.
- FSM states IDLE, ISSUE, RESP:
  - IDLE:
    - If any reqN_valid, grant one requester.
    - reqN_ready is high combinationally only for the granted requester; the accept occurs on that edge.
    - Register opcode, a, b and carry_in into alu_* outputs and record the grant id. Go to ISSUE.
  - ISSUE:
    - The ALU settles on the registered inputs.
    - At the end of the cycle, capture alu_y and the flags into resp_y/resp_flags and set resp_id.
    - If alu_invalid_op is high, increment invalid_count.
    - Go to RESP.
  - RESP:
    - resp_valid=1. resp_y, resp_flags and resp_id stay stable until resp_valid && resp_ready.
    - On that handshake, go to IDLE with resp_valid=0 on the next cycle.
- No reqN_ready is asserted outside IDLE: one op in flight at a time.
- Latency: accept at edge T, resp_valid high from T+2; minimum 3 cycles per op.
- Arbitration:
  - Only one valid: it wins regardless of the pointer.
  - Both valid: the requester not granted last wins.
  - The pointer updates only on an accept.
- alu_* outputs hold their last values outside ISSUE; alu_opcode returns to 0 only on reset.
- invalid_count saturates at all-ones and does not wrap.
- Requesters must hold reqN_valid and their payload stable until reqN_ready. reqN_valid must not depend on reqN_ready.
- resp_ready is sampled only in RESP; when resp_ready is held high, the op completes in 3 cycles.

Decomposition:
- Shared package (alu_pkg): opcode constants OP_INVALID=0, OP_ADD=1, OP_ADD_CARRY=2, OP_SUB=3, OP_INC=4, OP_DEC=5, OP_AND=6, OP_NOT=7, OP_ROL=8, OP_ROR=9; flag bit-index constants; FSM state encodings.
- One natural sub-module: rr_arbiter2, holding the two-input round-robin grant logic and pointer register.

Test Plan:
- Reset, then req0 ADD a=9, b=33, cin=0, resp_ready=1:
  - accept at T; resp_valid at T+2.
  - resp_id=0, resp_y=42, all flags 0 except parity per ALU.
- req0 and req1 both valid on the same cycle after reset (req0 SUB 65-64, req1 SUB 65-66):
  - req0 served first with y=1, borrow=0.
  - req1 served next with y=255, borrow=1.
- Both requesters hold valid continuously for 4 ops:
  - grants alternate 0,1,0,1; accepts are no closer than 3 cycles apart.
- resp_ready held low for 5 cycles in RESP:
  - resp_valid, resp_y and resp_flags stay stable.
  - No reqN_ready is asserted.
  - The op completes one cycle after resp_ready rises.
- req1 opcode=0 (OP_INVALID):
  - resp_flags[4]=1 and invalid_count increments by 1.
  - Forcing invalid_count to all-ones, then another invalid op, leaves it at all-ones.
- rst_n low during ISSUE:
  - Next cycle state=IDLE, resp_valid=0, alu_opcode=0.
  - No response is ever issued for the discarded op.
